mem_bus_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory bus between instruction fetch (IF) and the data-memory stage (MEM).
- Sequences each bus transaction with a req/ack handshake and a watchdog.
- Produces per-stage stall requests for the pipeline stall controller, so a stage holds while its access is outstanding.
- MEM has fixed priority over IF, because MEM always carries the older instruction.

---
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-port memory bus arbiter for IF and MEM stages with watchdog
// MEM has fixed priority over IF; each transaction is req/ack sequenced and aborted after MAX_WAIT cycles.
module mem_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          stallreq_from_if,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [3:0]    mem_sel,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          stallreq_from_mem,
  output logic          bus_req,
  output logic          bus_we,
  output logic [3:0]    bus_sel,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          bus_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_BUSY = 3'd1,
    IF_BUSY  = 3'd2,
    MEM_DONE = 3'd3,
    IF_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(MAX_WAIT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] watchdog;
  logic       discard;
  logic       wd_expired;
  logic       if_drop;

  assign wd_expired = (watchdog == WD_LAST);
  // A flush in the completing cycle itself also drops the fetched word.
  assign if_drop    = discard | flush;

  assign stallreq_from_mem = mem_req & (state != MEM_DONE);
  assign stallreq_from_if  = if_req & ~flush & (state != IF_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem_req)               state_next = MEM_BUSY;
        else if (if_req && !flush) state_next = IF_BUSY;
      end
      MEM_BUSY: begin
        if (bus_ack || wd_expired) state_next = MEM_DONE;
      end
      IF_BUSY: begin
        if (bus_ack || wd_expired) state_next = if_drop ? IDLE : IF_DONE;
      end
      MEM_DONE: state_next = IDLE;
      IF_DONE:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'h0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      watchdog  <= 8'd0;
      discard   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          watchdog <= 8'd0;
          discard  <= 1'b0;
          if (mem_req) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (if_req && !flush) begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_sel  <= 4'hF;
            bus_addr <= if_addr;
          end
        end
        MEM_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) mem_rdata <= bus_rdata;
          end else if (wd_expired) begin
            bus_req   <= 1'b0;
            bus_err   <= 1'b1;
            mem_rdata <= '0;
          end else begin
            watchdog <= watchdog + 8'd1;
          end
        end
        IF_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            discard <= 1'b0;
            if (!if_drop) if_rdata <= bus_rdata;
          end else if (wd_expired) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            discard <= 1'b0;
            if (!if_drop) if_rdata <= '0;
          end else begin
            watchdog <= watchdog + 8'd1;
            discard  <= if_drop;
          end
        end
        default: begin
          watchdog <= 8'd0;
          discard  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        stallreq_from_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stallreq_from_mem;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        chk_wdata;
  } txn_t;

  txn_t exp_q[$];
  logic req_q = 1'b0;

  mem_bus_arbiter #(.AW(32), .DW(32), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .stallreq_from_if(stallreq_from_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stallreq_from_mem(stallreq_from_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic we, input logic [3:0] sel,
                      input logic [31:0] wd, input logic cw);
    txn_t t;
    t.addr = a; t.we = we; t.sel = sel; t.wdata = wd; t.chk_wdata = cw;
    exp_q.push_back(t);
  endtask

  // Each rising bus_req is matched against the oldest expected transaction.
  always @(negedge clk) begin
    if (bus_req && !req_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bus_req", 32'(bus_req), 32'd0);
      end else begin
        txn_t t;
        t = exp_q.pop_front();
        check("bus_addr", bus_addr, t.addr);
        check("bus_we", 32'(bus_we), 32'(t.we));
        check("bus_sel", 32'(bus_sel), 32'(t.sel));
        if (t.chk_wdata) check("bus_wdata", bus_wdata, t.wdata);
      end
    end
    req_q = bus_req;
  end

  // Called in the first bus_req cycle; returns in the DONE cycle after acking at cycle lat.
  task automatic serve(input int lat, input logic [31:0] data, input logic e_if, input logic e_mem);
    for (int i = 1; i < lat; i++) begin
      check("busy_bus_req", 32'(bus_req), 32'd1);
      check("busy_stall_if", 32'(stallreq_from_if), 32'(e_if));
      check("busy_stall_mem", 32'(stallreq_from_mem), 32'(e_mem));
      cyc();
    end
    check("ack_cycle_bus_req", 32'(bus_req), 32'd1);
    bus_ack = 1'b1;
    bus_rdata = data;
    cyc();
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = '0; mem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_stall_if", 32'(stallreq_from_if), 32'd0);

    // IF read, ack in the 3rd bus_req cycle
    if_req = 1'b1; if_addr = 32'h0000_0400;
    push(32'h0000_0400, 1'b0, 4'hF, 32'h0, 1'b0);
    #1;
    check("t1_stall_if_idle", 32'(stallreq_from_if), 32'd1);
    cyc();
    serve(3, 32'h2402_000A, 1'b1, 1'b0);
    check("t1_bus_req_done", 32'(bus_req), 32'd0);
    check("t1_stall_if_done", 32'(stallreq_from_if), 32'd0);
    check("t1_if_rdata", if_rdata, 32'h2402_000A);
    if_req = 1'b0;
    cyc();
    check("t1_idle_bus_req", 32'(bus_req), 32'd0);

    // Simultaneous IF and MEM: MEM first
    if_req = 1'b1; if_addr = 32'h0000_0100;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_2000;
    push(32'h0000_2000, 1'b0, 4'hF, 32'h0, 1'b0);
    push(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0);
    #1;
    check("t2_stall_mem", 32'(stallreq_from_mem), 32'd1);
    cyc();
    serve(2, 32'hCAFE_0001, 1'b1, 1'b1);
    check("t2_mem_rdata", mem_rdata, 32'hCAFE_0001);
    check("t2_stall_mem_done", 32'(stallreq_from_mem), 32'd0);
    check("t2_stall_if_memdone", 32'(stallreq_from_if), 32'd1);
    mem_req = 1'b0;
    cyc();
    check("t2_gap_bus_req", 32'(bus_req), 32'd0);
    check("t2_stall_if_gap", 32'(stallreq_from_if), 32'd1);
    cyc();
    serve(1, 32'h1111_2222, 1'b1, 1'b0);
    check("t2_if_rdata", if_rdata, 32'h1111_2222);
    check("t2_stall_if_done", 32'(stallreq_from_if), 32'd0);
    if_req = 1'b0;
    cyc();

    // MEM write leaves mem_rdata alone
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
    mem_addr = 32'h0000_0040; mem_wdata = 32'hDEAD_BEEF;
    push(32'h0000_0040, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b1);
    cyc();
    serve(2, 32'h5555_5555, 1'b0, 1'b1);
    check("t3_mem_rdata_kept", mem_rdata, 32'hCAFE_0001);
    check("t3_stall_mem_done", 32'(stallreq_from_mem), 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    cyc();

    // Flush mid IF_BUSY: ack data discarded, returns straight to IDLE
    if_req = 1'b1; if_addr = 32'h0000_0200;
    push(32'h0000_0200, 1'b0, 4'hF, 32'h0, 1'b0);
    cyc();
    cyc();
    flush = 1'b1;
    #1;
    check("t4_stall_if_flush", 32'(stallreq_from_if), 32'd0);
    cyc();
    flush = 1'b0; if_req = 1'b0;
    check("t4_bus_req_held", 32'(bus_req), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h0000_1234;
    cyc();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    check("t4_bus_req_after_ack", 32'(bus_req), 32'd0);
    check("t4_if_rdata_kept", if_rdata, 32'h1111_2222);
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0080;
    push(32'h0000_0080, 1'b0, 4'hF, 32'h0, 1'b0);
    cyc();
    check("t4_idle_not_done", 32'(bus_req), 32'd1);
    serve(1, 32'h0BAD_F00D, 1'b0, 1'b1);
    check("t4_mem_rdata", mem_rdata, 32'h0BAD_F00D);
    mem_req = 1'b0;
    cyc();

    // Watchdog abort after 16 BUSY cycles, late ack ignored
    mem_req = 1'b1; mem_addr = 32'h0000_0300;
    push(32'h0000_0300, 1'b0, 4'hF, 32'h0, 1'b0);
    cyc();
    for (int i = 1; i < 16; i++) begin
      check("t5_wait_bus_req", 32'(bus_req), 32'd1);
      check("t5_wait_bus_err", 32'(bus_err), 32'd0);
      cyc();
    end
    check("t5_last_bus_req", 32'(bus_req), 32'd1);
    cyc();
    check("t5_abort_bus_req", 32'(bus_req), 32'd0);
    check("t5_abort_bus_err", 32'(bus_err), 32'd1);
    check("t5_abort_rdata", mem_rdata, 32'd0);
    check("t5_abort_stall_mem", 32'(stallreq_from_mem), 32'd0);
    mem_req = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    cyc();
    check("t5_err_pulse_end", 32'(bus_err), 32'd0);
    cyc();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    check("t5_late_ack_rdata", mem_rdata, 32'd0);
    check("t5_late_ack_bus_req", 32'(bus_req), 32'd0);

    // Reset during MEM_BUSY with a coincident ack
    mem_req = 1'b1; mem_addr = 32'h0000_0500;
    push(32'h0000_0500, 1'b0, 4'hF, 32'h0, 1'b0);
    cyc();
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    cyc();
    rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0; mem_req = 1'b0;
    #1;
    check("t6_bus_req", 32'(bus_req), 32'd0);
    check("t6_mem_rdata", mem_rdata, 32'd0);
    check("t6_bus_err", 32'(bus_err), 32'd0);
    if_req = 1'b1; if_addr = 32'h0000_0600;
    push(32'h0000_0600, 1'b0, 4'hF, 32'h0, 1'b0);
    cyc();
    check("t6_idle_launch", 32'(bus_req), 32'd1);
    serve(2, 32'hA5A5_5A5A, 1'b1, 1'b0);
    check("t6_if_rdata", if_rdata, 32'hA5A5_5A5A);
    if_req = 1'b0;
    cyc();
    cyc();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
